// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the Harvard-to-Avalon bridge.
package avalon_bridge_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    DATA,
    EXEC,
    HALT
  } bridge_state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  // Avalon slaves in this system are word addressed, so byte offsets are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/avalon_harvard_bridge_if.sv
// Avalon-MM master/slave signal bundle used between the bridge and the interconnect.
interface avalon_harvard_bridge_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );

endinterface

// File: rtl/bridge_wait_timer.sv
// Counts consecutive stalled cycles of one bus request and flags a timeout.
// TIMEOUT = 0 disables the timeout entirely.
module bridge_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic waitrequest,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Stall counter: restarts whenever the request is accepted, dropped or times out.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!active || !waitrequest || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Expiry fires in the stalled cycle that would bring the count up to TIMEOUT.
  always_comb begin
    expired = (TIMEOUT != 0) && active && waitrequest && (count == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/avalon_harvard_bridge.sv
// Sequences a Harvard MIPS core over a single Avalon-MM master port:
// fetch, decode, optional data access, then a one-cycle execute strobe.
module avalon_harvard_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_active,
  input  logic [31:0]            cpu_instr_address,
  output logic [31:0]            cpu_instr_readdata,
  input  logic [31:0]            cpu_data_address,
  input  logic                   cpu_data_read,
  input  logic                   cpu_data_write,
  input  logic [31:0]            cpu_data_writedata,
  output logic [31:0]            cpu_data_readdata,
  output logic                   cpu_clk_enable,
  avalon_harvard_bridge_if.master avm,
  output logic                   bus_error,
  output logic [CNT_W-1:0]       instr_retired
);

  bridge_state_t state;
  bridge_state_t next_state;
  logic          bus_active;
  logic          timer_expired;

  bridge_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .active     (bus_active),
    .waitrequest(avm.waitrequest),
    .expired    (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus/strobe decode; requests are masked while reset is high
  // so a stalled transfer is abandoned immediately.
  always_comb begin
    next_state     = state;
    bus_active     = 1'b0;
    avm.address    = '0;
    avm.read       = 1'b0;
    avm.write      = 1'b0;
    avm.writedata  = '0;
    avm.byteenable = BYTEEN_ALL;
    cpu_clk_enable = 1'b0;
    case (state)
      FETCH: begin
        bus_active  = 1'b1;
        avm.read    = 1'b1;
        avm.address = word_align(cpu_instr_address);
        if (timer_expired) begin
          next_state = HALT;
        end else if (!avm.waitrequest) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (!cpu_active) begin
          next_state = HALT;
        end else if (cpu_data_write || cpu_data_read) begin
          next_state = DATA;
        end else begin
          next_state = EXEC;
        end
      end
      DATA: begin
        bus_active  = 1'b1;
        avm.address = word_align(cpu_data_address);
        if (cpu_data_write) begin
          avm.write     = 1'b1;
          avm.writedata = cpu_data_writedata;
        end else begin
          avm.read = 1'b1;
        end
        if (timer_expired) begin
          next_state = HALT;
        end else if (!avm.waitrequest) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        cpu_clk_enable = 1'b1;
        next_state     = FETCH;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
    if (reset) begin
      avm.read       = 1'b0;
      avm.write      = 1'b0;
      cpu_clk_enable = 1'b0;
    end
  end

  // Instruction/load latches, sticky bus error and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_instr_readdata <= '0;
      cpu_data_readdata  <= '0;
      bus_error          <= 1'b0;
      instr_retired      <= '0;
    end else begin
      if (state == FETCH && !avm.waitrequest) begin
        cpu_instr_readdata <= avm.readdata;
      end
      if (state == DATA && !avm.waitrequest && !cpu_data_write) begin
        cpu_data_readdata <= avm.readdata;
      end
      if (timer_expired) begin
        bus_error <= 1'b1;
      end
      if (state == EXEC) begin
        instr_retired <= instr_retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_avalon_harvard_bridge.sv
// Directed self-checking bench for avalon_harvard_bridge: the bench plays both the
// CPU and the Avalon slave, with a scoreboard of expected bus transfers and load words.
module tb_avalon_harvard_bridge;
  import avalon_bridge_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } bus_txn_t;

  localparam logic [31:0] ADDIU_W = 32'h2408_0005;
  localparam logic [31:0] JR_W    = 32'h0000_0008;
  localparam logic [31:0] NOP_W   = 32'h0000_0000;
  localparam logic [31:0] LW_W    = 32'h8D49_0004;
  localparam logic [31:0] SW_W    = 32'hAD49_0002;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic        bus_error;
  logic [31:0] instr_retired;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  bus_txn_t    expBus[$];
  logic [31:0] expLoad[$];
  logic [31:0] lastLoad;
  logic [31:0] expRetired;

  avalon_harvard_bridge_if bus ();

  avalon_harvard_bridge #(
    .TIMEOUT(4),
    .CNT_W  (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_active        (cpu_active),
    .cpu_instr_address (cpu_instr_address),
    .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata (cpu_data_readdata),
    .cpu_clk_enable    (cpu_clk_enable),
    .avm               (bus),
    .bus_error         (bus_error),
    .instr_retired     (instr_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic act, input logic [31:0] pc, input logic [31:0] daddr,
                               input logic rd, input logic wr, input logic [31:0] wdata);
    cpu_active         = act;
    cpu_instr_address  = pc;
    cpu_data_address   = daddr;
    cpu_data_read      = rd;
    cpu_data_write     = wr;
    cpu_data_writedata = wdata;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'hFFFF_FFFF;
    step();
    step();
    checkOutput("reset idle", {29'b0, bus.read, bus.write, cpu_clk_enable}, 32'h0);
    checkOutput("reset instr", cpu_instr_readdata, 32'h0);
    checkOutput("reset load", cpu_data_readdata, 32'h0);
    checkOutput("reset bus_error", 32'(bus_error), 32'h0);
    checkOutput("reset retired", instr_retired, 32'h0);
    reset      = 1'b0;
    expRetired = 32'h0;
    lastLoad   = 32'h0;
    expBus.delete();
    expLoad.delete();
  endtask

  // Called at the start of a FETCH cycle; drives one full instruction sequence.
  task automatic runInstr(input string name, input logic [31:0] pc, input logic [31:0] word,
                          input logic act, input logic rd, input logic wr,
                          input logic [31:0] daddr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int fWaits, input int dWaits);
    bus_txn_t t;
    bus_txn_t cur;
    int       cycles;
    int       expCycles;
    logic     mem;
    mem       = act && (rd || wr);
    cycles    = 0;
    expCycles = 3 + fWaits + (mem ? 1 + dWaits : 0);
    applyStimulus(act, pc, daddr, rd, wr, wdata);
    t.addr  = pc & 32'hFFFF_FFFC;
    t.wr    = 1'b0;
    t.wdata = 32'h0;
    expBus.push_back(t);
    if (mem) begin
      t.addr  = daddr & 32'hFFFF_FFFC;
      t.wr    = wr;
      t.wdata = wdata;
      expBus.push_back(t);
      if (!wr) lastLoad = rdata;
    end
    if (act) expLoad.push_back(lastLoad);

    for (int i = 0; i <= fWaits; i++) begin
      bus.waitrequest = (i < fWaits);
      bus.readdata    = (i < fWaits) ? (32'hA5A5_0000 + 32'(i)) : word;
      #1;
      cur = expBus[0];
      checkOutput({name, " fetch read"}, 32'(bus.read), 32'h1);
      checkOutput({name, " fetch write"}, 32'(bus.write), 32'h0);
      checkOutput({name, " fetch addr"}, bus.address, cur.addr);
      if (i == fWaits) void'(expBus.pop_front());
      cycles++;
      step();
    end

    bus.waitrequest = 1'b0;
    bus.readdata    = 32'hFEED_0000 ^ pc;
    #1;
    checkOutput({name, " decode idle"}, {29'b0, bus.read, bus.write, cpu_clk_enable}, 32'h0);
    checkOutput({name, " decode instr"}, cpu_instr_readdata, word);
    cycles++;
    step();
    if (!act) return;

    if (mem) begin
      for (int i = 0; i <= dWaits; i++) begin
        bus.waitrequest = (i < dWaits);
        bus.readdata    = (i < dWaits) ? (32'h5A5A_0000 + 32'(i)) : rdata;
        #1;
        cur = expBus[0];
        checkOutput({name, " data addr"}, bus.address, cur.addr);
        checkOutput({name, " data write"}, 32'(bus.write), 32'(cur.wr));
        checkOutput({name, " data read"}, 32'(bus.read), 32'(!cur.wr));
        checkOutput({name, " data byteenable"}, 32'(bus.byteenable), 32'h0000_000F);
        if (cur.wr) checkOutput({name, " data writedata"}, bus.writedata, cur.wdata);
        if (i == dWaits) void'(expBus.pop_front());
        cycles++;
        step();
      end
    end

    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h0F0F_0F0F;
    #1;
    checkOutput({name, " exec strobe"}, 32'(cpu_clk_enable), 32'h1);
    checkOutput({name, " exec idle"}, {30'b0, bus.read, bus.write}, 32'h0);
    checkOutput({name, " exec instr"}, cpu_instr_readdata, word);
    checkOutput({name, " exec load"}, cpu_data_readdata, expLoad.pop_front());
    checkOutput({name, " exec retired"}, instr_retired, expRetired);
    cycles++;
    checkOutput({name, " cycles"}, 32'(cycles), 32'(expCycles));
    expRetired = expRetired + 32'h1;
    step();
  endtask

  task automatic checkHalt(input string name, input int n, input logic expErr);
    for (int i = 0; i < n; i++) begin
      bus.waitrequest = 1'b0;
      bus.readdata    = $urandom;
      #1;
      checkOutput({name, " halt idle"}, {29'b0, bus.read, bus.write, cpu_clk_enable}, 32'h0);
      checkOutput({name, " halt bus_error"}, 32'(bus_error), 32'(expErr));
      checkOutput({name, " halt retired"}, instr_retired, expRetired);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h0;
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Zero-wait program ADDIU, JR $0, delay slot, then the core goes inactive.
    doReset();
    runInstr("t1 addiu", 32'h0, ADDIU_W, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    runInstr("t1 jr", 32'h4, JR_W, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    runInstr("t1 slot", 32'h8, NOP_W, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    runInstr("t1 halt", 32'h0, ADDIU_W, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    checkHalt("t1", 6, 1'b0);

    // Loads and stores with wait states; three fetch stalls stays under the timeout.
    doReset();
    runInstr("t2 lw", 32'h100, LW_W, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h0, 32'hDEAD_BEEF, 3, 2);
    runInstr("t3 sw", 32'h104, SW_W, 1'b1, 1'b0, 1'b1, 32'h2002, 32'h1234_5678, 32'h0, 0, 0);
    runInstr("t6 both", 32'h108, SW_W, 1'b1, 1'b1, 1'b1, 32'h3008, 32'hCAFE_F00D, 32'h5555_5555, 0, 1);
    runInstr("t2b lw", 32'h10C, LW_W, 1'b1, 1'b1, 1'b0, 32'h4003, 32'h0, 32'h0BAD_C0DE, 1, 0);
    runInstr("t2c addiu", 32'h110, ADDIU_W, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2, 0);

    // Reset arriving while a store is stalled in DATA.
    doReset();
    runInstr("t5 addiu", 32'h0, ADDIU_W, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1'b1, 32'h4, 32'h4000, 1'b0, 1'b1, 32'h1111_2222);
    bus.waitrequest = 1'b0;
    bus.readdata    = SW_W;
    #1;
    checkOutput("t5 fetch read", 32'(bus.read), 32'h1);
    step();
    #1;
    checkOutput("t5 decode instr", cpu_instr_readdata, SW_W);
    step();
    bus.waitrequest = 1'b1;
    #1;
    checkOutput("t5 stalled write", 32'(bus.write), 32'h1);
    checkOutput("t5 stalled addr", bus.address, 32'h0000_4000);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checkOutput("t5 write dropped", 32'(bus.write), 32'h0);
    checkOutput("t5 back to fetch", 32'(bus.read), 32'h1);
    checkOutput("t5 fetch addr", bus.address, 32'h0000_0004);
    checkOutput("t5 retired cleared", instr_retired, 32'h0);
    checkOutput("t5 bus_error clear", 32'(bus_error), 32'h0);

    // Fetch stalled forever: request dropped after four wait cycles, sticky error, halt.
    doReset();
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.waitrequest = 1'b1;
      #1;
      checkOutput("t4 stalled read", 32'(bus.read), 32'h1);
      checkOutput("t4 no error yet", 32'(bus_error), 32'h0);
      step();
    end
    bus.waitrequest = 1'b1;
    #1;
    checkOutput("t4 read dropped", 32'(bus.read), 32'h0);
    checkOutput("t4 bus_error set", 32'(bus_error), 32'h1);
    step();
    checkHalt("t4", 5, 1'b1);

    // The bridge recovers normally after reset.
    doReset();
    runInstr("t4 recover", 32'h80, ADDIU_W, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
